// File: rtl/varre_triangulo.sv
// varre_triangulo: latches a triangle, derives its bounding box and rasters
// every integer point of that box, one per clock. The external point test
// (dentroTriang) answers combinationally on `dentro`; hits are counted and the
// total is reported with a one-cycle `done` pulse.
module varre_triangulo #(
  parameter int unsigned W  = 11,
  parameter int unsigned CW = 2 * W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] p1x,
  input  logic signed [W-1:0] p1y,
  input  logic signed [W-1:0] p2x,
  input  logic signed [W-1:0] p2y,
  input  logic signed [W-1:0] p3x,
  input  logic signed [W-1:0] p3y,
  output logic signed [W-1:0] ptx,
  output logic signed [W-1:0] pty,
  input  logic                dentro,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       count
);

  typedef enum logic [1:0] {
    StIdle,
    StBbox,
    StScan,
    StFim
  } state_e;

  localparam logic signed [W-1:0] One = W'(1);

  state_e state_q, state_d;

  // Latched vertices; only written on the edge that accepts `start`.
  logic signed [W-1:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic signed [W-1:0] v1x_d, v1y_d, v2x_d, v2y_d, v3x_d, v3y_d;

  // Box limits needed while scanning (ymin only matters at load time).
  logic signed [W-1:0] xmin_q, xmax_q, ymax_q;
  logic signed [W-1:0] xmin_d, xmax_d, ymax_d;

  logic signed [W-1:0] ptx_q, pty_q, ptx_d, pty_d;
  logic [CW-1:0]       acc_q, acc_d;

  logic signed [W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;

  function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic signed [W-1:0] c);
    logic signed [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic signed [W-1:0] c);
    logic signed [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Bounding box of the latched vertices, signed compares.
  always_comb begin
    xmin_c = min3(v1x_q, v2x_q, v3x_q);
    xmax_c = max3(v1x_q, v2x_q, v3x_q);
    ymin_c = min3(v1y_q, v2y_q, v3y_q);
    ymax_c = max3(v1y_q, v2y_q, v3y_q);
  end

  // Next-state logic: FSM, vertex latch, box load, raster walk and hit count.
  always_comb begin
    state_d = state_q;
    v1x_d   = v1x_q;
    v1y_d   = v1y_q;
    v2x_d   = v2x_q;
    v2y_d   = v2y_q;
    v3x_d   = v3x_q;
    v3y_d   = v3y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    ptx_d   = ptx_q;
    pty_d   = pty_q;
    acc_d   = acc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          v1x_d   = p1x;
          v1y_d   = p1y;
          v2x_d   = p2x;
          v2y_d   = p2y;
          v3x_d   = p3x;
          v3y_d   = p3y;
          state_d = StBbox;
        end
      end
      StBbox: begin
        xmin_d  = xmin_c;
        xmax_d  = xmax_c;
        ymax_d  = ymax_c;
        ptx_d   = xmin_c;
        pty_d   = ymin_c;
        acc_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        // `dentro` belongs to the point shown this cycle.
        acc_d = acc_q + CW'(dentro);
        if (ptx_q != xmax_q) begin
          ptx_d = ptx_q + One;
        end else if (pty_q != ymax_q) begin
          ptx_d = xmin_q;
          pty_d = pty_q + One;
        end else begin
          // Last point: keep it on the outputs and finish.
          state_d = StFim;
        end
      end
      StFim: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      v1x_q   <= '0;
      v1y_q   <= '0;
      v2x_q   <= '0;
      v2y_q   <= '0;
      v3x_q   <= '0;
      v3y_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      ptx_q   <= '0;
      pty_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      v1x_q   <= v1x_d;
      v1y_q   <= v1y_d;
      v2x_q   <= v2x_d;
      v2y_q   <= v2y_d;
      v3x_q   <= v3x_d;
      v3y_q   <= v3y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      ptx_q   <= ptx_d;
      pty_q   <= pty_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs decoded from registered state; the accumulator doubles as `count`.
  always_comb begin
    ptx   = ptx_q;
    pty   = pty_q;
    busy  = (state_q == StBbox) || (state_q == StScan);
    done  = (state_q == StFim);
    count = acc_q;
  end

endmodule

// File: tb/tb_varre_triangulo.sv
// Bench for varre_triangulo: drives random and directed triangles, models the
// external point test and compares each scanned point, the flags and the count.
module tb_varre_triangulo;

  localparam int W  = 11;
  localparam int CW = 2 * W + 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic signed [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic signed [W-1:0] ptx, pty;
  logic                dentro;
  logic                busy, done;
  logic [CW-1:0]       count;

  int checks = 0;
  int errors = 0;

  // Environment model: 0 tied low, 1 tied high, 2 triangle test, 3 pattern.
  int mode = 1;
  int salt = 0;
  int tx[3] = '{0, 0, 0};
  int ty[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  varre_triangulo #(.W(W), .CW(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .p1x    (p1x),
    .p1y    (p1y),
    .p2x    (p2x),
    .p2y    (p2y),
    .p3x    (p3x),
    .p3y    (p3y),
    .ptx    (ptx),
    .pty    (pty),
    .dentro (dentro),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  function automatic logic dentro_f(input int m, input int s, input int px, input int py,
                                    input int x0, input int y0, input int x1, input int y1,
                                    input int x2, input int y2);
    int d1, d2, d3;
    bit neg, pos;
    case (m)
      0: return 1'b0;
      1: return 1'b1;
      2: begin
        d1  = (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
        d2  = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
        d3  = (x0 - x2) * (py - y2) - (y0 - y2) * (px - x2);
        neg = (d1 < 0) || (d2 < 0) || (d3 < 0);
        pos = (d1 > 0) || (d2 > 0) || (d3 > 0);
        return !(neg && pos);
      end
      default: return ((px * 5 + py * 3 + s) & 3) == 0;
    endcase
  endfunction

  always_comb begin
    dentro = dentro_f(mode, salt, int'(ptx), int'(pty), tx[0], ty[0], tx[1], ty[1],
                      tx[2], ty[2]);
  end

  task automatic launch(input int ax, input int ay, input int bx, input int by,
                        input int cx, input int cy);
    @(negedge clk);
    p1x = W'(ax); p1y = W'(ay);
    p2x = W'(bx); p2y = W'(by);
    p3x = W'(cx); p3y = W'(cy);
    tx[0] = ax; ty[0] = ay;
    tx[1] = bx; ty[1] = by;
    tx[2] = cx; ty[2] = cy;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Call right after the accepting edge. Returns in the first IDLE cycle.
  task automatic check_scan(input string name, input int repulse_at, input bit hold_fim,
                            output int got_cnt);
    int xmin, xmax, ymin, ymax, exp_cnt, i;
    xmin = tx[0]; xmax = tx[0]; ymin = ty[0]; ymax = ty[0];
    for (int k = 1; k < 3; k++) begin
      if (tx[k] < xmin) xmin = tx[k];
      if (tx[k] > xmax) xmax = tx[k];
      if (ty[k] < ymin) ymin = ty[k];
      if (ty[k] > ymax) ymax = ty[k];
    end
    exp_cnt = 0;
    i = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL %s bbox_flags: busy=%b done=%b need 1/0", name, busy, done); end
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        @(negedge clk);
        if (repulse_at >= 0 && i == repulse_at + 1) start = 1'b0;
        checks++;
        if (ptx !== W'(x) || pty !== W'(y)) begin
          errors++;
          $display("FAIL %s point%0d: got (%0d,%0d) need (%0d,%0d)", name, i,
                   int'(ptx), int'(pty), x, y);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0)
          begin errors++; $display("FAIL %s scan_flags%0d: busy=%b done=%b need 1/0", name, i, busy, done); end
        exp_cnt += int'(dentro_f(mode, salt, x, y, tx[0], ty[0], tx[1], ty[1], tx[2], ty[2]));
        if (i == repulse_at) begin
          start = 1'b1;
          p1x = W'(-40); p1y = W'(30);
          p2x = W'(50);  p2y = W'(-60);
          p3x = W'(2);   p3y = W'(9);
        end
        i++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL %s fim_flags: done=%b busy=%b need 1/0", name, done, busy); end
    checks++;
    if (count !== CW'(exp_cnt))
      begin errors++; $display("FAIL %s count: got %0d need %0d", name, count, exp_cnt); end
    checks++;
    if (ptx !== W'(xmax) || pty !== W'(ymax)) begin
      errors++;
      $display("FAIL %s fim_point: got (%0d,%0d) need (%0d,%0d)", name, int'(ptx), int'(pty),
               xmax, ymax);
    end
    start = hold_fim;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL %s idle_flags: done=%b busy=%b need 0/0", name, done, busy); end
    checks++;
    if (count !== CW'(exp_cnt))
      begin errors++; $display("FAIL %s count_hold: got %0d need %0d", name, count, exp_cnt); end
    checks++;
    if (ptx !== W'(xmax) || pty !== W'(ymax))
      begin errors++; $display("FAIL %s idle_point: got (%0d,%0d)", name, int'(ptx), int'(pty)); end
    got_cnt = int'(count);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ptx !== '0 || pty !== '0 || busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset: ptx=%0d pty=%0d busy=%b done=%b count=%0d need all 0",
               int'(ptx), int'(pty), busy, done, count);
    end
  endtask

  task automatic test_tied_one();
    int c;
    mode = 1;
    launch(0, 0, 4, 0, 0, 4);
    check_scan("tied_one", -1, 1'b0, c);
    checks++;
    if (c != 25) begin errors++; $display("FAIL tied_one_n: got %0d need 25", c); end
  endtask

  task automatic test_triangle();
    int c;
    mode = 2;
    launch(0, 0, 4, 0, 0, 4);
    check_scan("triangle", -1, 1'b0, c);
    checks++;
    if (c != 15) begin errors++; $display("FAIL triangle_hits: got %0d need 15", c); end
  endtask

  task automatic test_negative();
    int c;
    mode = 0;
    launch(-3, 2, 1, -2, -1, 0);
    check_scan("negative", -1, 1'b0, c);
  endtask

  task automatic test_degenerate();
    int c;
    mode = 1;
    launch(7, -5, 7, -5, 7, -5);
    check_scan("degenerate", -1, 1'b0, c);
    checks++;
    if (c != 1) begin errors++; $display("FAIL degenerate_n: got %0d need 1", c); end
  endtask

  task automatic test_repulse();
    int c;
    mode = 3;
    salt = 1;
    launch(-2, -1, 3, 2, 0, 3);
    check_scan("repulse", 6, 1'b0, c);
    // No second scan may follow the ignored start.
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL repulse_quiet: busy=%b done=%b need 0/0", busy, done); end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    mode = 2;
    launch(1, 1, 5, 2, 2, 4);
    check_scan("b2b_first", -1, 1'b1, c);
    @(posedge clk);
    #1 start = 1'b0;
    check_scan("b2b_second", -1, 1'b0, c);
  endtask

  task automatic test_mid_reset();
    int c;
    mode = 1;
    launch(0, 0, 6, 0, 0, 6);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ptx !== '0 || pty !== '0 || busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL mid_reset: ptx=%0d pty=%0d busy=%b done=%b count=%0d need all 0",
               int'(ptx), int'(pty), busy, done, count);
    end
    repeat (50) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL mid_reset_quiet: busy=%b done=%b need 0/0", busy, done); end
    end
    mode = 2;
    launch(-1, -1, 3, 0, 1, 3);
    check_scan("after_reset", -1, 1'b0, c);
  endtask

  task automatic test_random();
    int c;
    int v[6];
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 6; k++) v[k] = int'($urandom_range(12)) - 6;
      mode = int'($urandom_range(3));
      salt = int'($urandom_range(255));
      launch(v[0], v[1], v[2], v[3], v[4], v[5]);
      check_scan("random", -1, 1'b0, c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
    test_reset();
    test_tied_one();
    test_triangle();
    test_negative();
    test_degenerate();
    test_repulse();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/varre_triangulo.md
# varre_triangulo

Sequential scan stage that sits directly upstream of `dentroTriang`. On a `start` pulse it latches three signed vertices, computes their axis-aligned bounding box and walks every integer point of that box in raster order, one point per clock. It presents each point on `ptx`/`pty` to an external `dentroTriang` and accumulates that block's combinational `saida` into a hit count. When the scan ends it reports the count with a one-cycle `done` pulse.

## Interface
- `W`, 11, coordinate width (signed two's complement), matches `dentroTriang`
- `CW`, 2*W+1, hit-counter width; holds the full box of (2^W)^2 points
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request a scan; sampled only in IDLE
- `p1x`,`p1y`,`p2x`,`p2y`,`p3x`,`p3y`  in  W each, signed, triangle vertices; sampled on the edge that accepts `start`
- `ptx`,`pty`  out  W each, signed, current scan point, wired to `dentroTriang` inputs
- `dentro`  in  1  `saida` of `dentroTriang` for the current `ptx`/`pty`; combinational, same cycle
- `busy`  out  1  high from the accepting edge until `done` is asserted
- `done`  out  1  one-cycle pulse, final count valid
- `count`  out  CW  unsigned number of scanned points with `dentro`=1

## Operation
- States: IDLE, BBOX, SCAN, FIM.
- IDLE: `start`=1 latches the six vertices and moves to BBOX. `busy` goes high on the same edge.
- BBOX (1 cycle): compute xmin/xmax/ymin/ymax with signed compares over the latched vertices. Load `ptx`=xmin, `pty`=ymin and clear the accumulator. Go to SCAN.
- SCAN: one point per cycle. On each edge, the accumulator adds `dentro` (sampled for the point currently displayed), then the point advances:
  - if `ptx`≠xmax: `ptx`+1
  - else: `ptx`=xmin and `pty`+1
  - at (`ptx`=xmax, `pty`=ymax): the point is accumulated and the FSM goes to FIM instead of advancing.
- FIM (1 cycle): `done`=1, `busy`=0, `count`=final accumulator. Return to IDLE.
- `count` holds its value after `done` until the next accepted `start`. It is cleared in BBOX, not on `start`.
- `ptx`/`pty` hold the last scanned point in FIM and IDLE.
- Arithmetic:
  - compares and increments are W-bit signed
  - increments never overflow, because they stop at xmax/ymax ≤ 2^(W-1)-1
  - accumulator is CW-bit unsigned, saturation not needed
- Degenerate boxes (collinear or coincident vertices) are scanned normally. A single point gives N=1.
- `start` while `busy` is ignored and does not alter the latched vertices.
- Vertex changes after acceptance have no effect.

## Timing
- Reset values (`rst_n`=0 at an edge): state IDLE, `ptx`=0, `pty`=0, `busy`=0, `done`=0, `count`=0, accumulator 0. Reset overrides any state, including mid-SCAN, with no `done` pulse.
- Let N=(xmax-xmin+1)*(ymax-ymin+1). For `start` sampled at edge k:
  - BBOX runs in cycle k+1.
  - SCAN runs in cycles k+2 … k+1+N, with point i (0-based) on the outputs in cycle k+2+i.
  - `done`=1 in cycle k+2+N. `busy`=1 in cycles k+1 … k+1+N.
- Back-to-back: `start` may be high in the FIM cycle, but it is ignored there. The earliest accepted `start` is the first IDLE cycle, k+3+N.
- Combinational path `ptx`/`pty` → `dentroTriang` → `dentro` → accumulator must close in one clock.

## Test plan
- Vertices (0,0),(4,0),(0,4), `dentro` tied 1 → 25 SCAN cycles, points (0,0),(1,0)…(4,4) in raster order, `done` at k+27, `count`=25.
- Same vertices with a real `dentroTriang` → `count` equals the software model's count of the 25 points; each `ptx`/`pty` checked cycle by cycle.
- Negative box, vertices (-3,2),(1,-2),(-1,0), `dentro` tied 0 → box x −3..1, y −2..2, N=25, `count`=0, first point (−3,−2), last point (1,2).
- Degenerate triangle, all vertices (7,−5), `dentro`=1 → N=1, `done` at k+3, `count`=1, `ptx`/`pty`=(7,−5).
- `start` re-pulsed with other vertices during SCAN → ignored. `count`, N and latched box are unchanged, and there is exactly one `done`.
- `rst_n`=0 for one edge mid-SCAN → next cycle all outputs at reset values, no `done`. A new `start` then scans correctly from BBOX.
